mriscv_axi_ram: RTL and testbench

- AXI4-Lite slave memory that sits directly downstream of the mriscvcore AXI master port.
- The core fetches instructions and performs loads/stores through it.
- Word-organised SRAM with byte-lane writes via Wstrb and independent read and write channel state machines.
- One shared storage array; write commit has priority over read fetch.

---
 rtl/mriscv_axi_pkg.sv | 27 ++
 rtl/mriscv_ram_array.sv | 32 +++
 rtl/mriscv_axi_ram.sv | 217 +++++++++++++++++++++
 tb/tb_mriscv_axi_ram.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mriscv_axi_pkg.sv
// Shared constants for the mriscv AXI4-Lite RAM slave: bus widths, response
// codes, FSM encodings and the address range helper.
package mriscv_axi_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE   = 2'd0;
    localparam logic [1:0] W_COMMIT = 2'd1;
    localparam logic [1:0] W_RESP   = 2'd2;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_FETCH = 2'd1;
    localparam logic [1:0] R_WAIT  = 2'd2;
    localparam logic [1:0] R_RESP  = 2'd3;

    // Unsigned compare, so addresses below the base wrap high and fail.
    function automatic logic in_range(input logic [AXI_ADDR_W-1:0] off,
                                      input logic [AXI_ADDR_W-1:0] span);
        return off < span;
    endfunction

endpackage

// File: rtl/mriscv_ram_array.sv
// Single-port word SRAM with byte-lane write enables and a registered read port.
// Storage has no reset; rdata only updates on a pure read access.
module mriscv_ram_array
    import mriscv_axi_pkg::*;
#(
    parameter int unsigned WORDS = 4096,
    parameter int          IDX_W = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [AXI_STRB_W-1:0] we,
    input  logic [IDX_W-1:0]      addr,
    input  logic [AXI_DATA_W-1:0] wdata,
    output logic [AXI_DATA_W-1:0] rdata
);

    logic [AXI_DATA_W-1:0] mem_q [WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < AXI_STRB_W; i++) begin
                if (we[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            if (we == '0) begin
                rdata <= mem_q[addr];
            end
        end
    end

endmodule

// File: rtl/mriscv_axi_ram.sv
// AXI4-Lite slave RAM behind the mriscvcore master port, with independent
// write and read channel FSMs sharing one single-port array.
//
// state    | meaning
// W_IDLE   | collecting AW and W handshakes, in any order
// W_COMMIT | one-cycle array write of the enabled lanes (skipped if out of range)
// W_RESP   | Bvalid held until Bready
// R_IDLE   | ARready high, waiting for an address
// R_FETCH  | array read; stalls while a write commit owns the array
// R_WAIT   | down-counting the remaining read latency
// R_RESP   | Rvalid held with stable Rdata/Rresp until Rready
module mriscv_axi_ram
    import mriscv_axi_pkg::*;
#(
    parameter int unsigned           MEM_WORDS    = 4096,
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned           READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [AXI_ADDR_W-1:0] AWdata,
    input  logic                  AWvalid,
    output logic                  AWready,
    input  logic [2:0]            AWprot,
    input  logic [AXI_DATA_W-1:0] Wdata,
    input  logic [AXI_STRB_W-1:0] Wstrb,
    input  logic                  Wvalid,
    output logic                  Wready,
    output logic                  Bvalid,
    input  logic                  Bready,
    output logic [1:0]            Bresp,
    input  logic [AXI_ADDR_W-1:0] ARdata,
    input  logic                  ARvalid,
    output logic                  ARready,
    input  logic [2:0]            ARprot,
    output logic [AXI_DATA_W-1:0] Rdata,
    output logic                  Rvalid,
    input  logic                  Rready,
    output logic [1:0]            Rresp
);

    localparam int                    IDX_W  = $clog2(MEM_WORDS);
    localparam logic [AXI_ADDR_W-1:0] SPAN   = AXI_ADDR_W'(MEM_WORDS * 4);
    localparam logic [1:0]            LAT_M1 = 2'(READ_LATENCY - 1);

    logic [1:0]            w_state_q, w_state_d;
    logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [AXI_ADDR_W-1:0] aw_addr_q, aw_addr_d;
    logic [AXI_DATA_W-1:0] w_data_q, w_data_d;
    logic [AXI_STRB_W-1:0] w_strb_q, w_strb_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  awready_q, awready_d, wready_q, wready_d;

    logic [1:0]            r_state_q, r_state_d;
    logic [AXI_ADDR_W-1:0] ar_addr_q, ar_addr_d;
    logic [1:0]            r_cnt_q, r_cnt_d;
    logic                  arready_q, arready_d;

    logic [AXI_ADDR_W-1:0] w_off, r_off;
    logic                  w_in_range, r_in_range;
    logic [IDX_W-1:0]      w_idx, r_idx;
    logic                  ram_wr, ram_rd, ram_en;
    logic [AXI_STRB_W-1:0] ram_we;
    logic [IDX_W-1:0]      ram_addr;
    logic [AXI_DATA_W-1:0] ram_rdata;
    logic                  unused_prot;

    assign unused_prot = ^{AWprot, ARprot};

    assign w_off      = aw_addr_q - BASE_ADDR;
    assign r_off      = ar_addr_q - BASE_ADDR;
    assign w_in_range = in_range(w_off, SPAN);
    assign r_in_range = in_range(r_off, SPAN);
    assign w_idx      = w_off[IDX_W+1:2];
    assign r_idx      = r_off[IDX_W+1:2];

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bresp_d   = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (AWvalid && awready_q) begin
                    aw_addr_d = AWdata;
                    aw_held_d = 1'b1;
                end
                if (Wvalid && wready_q) begin
                    w_data_d = Wdata;
                    w_strb_d = Wstrb;
                    w_held_d = 1'b1;
                end
                if (aw_held_d && w_held_d) begin
                    w_state_d = W_COMMIT;
                end
            end
            W_COMMIT: begin
                bresp_d   = w_in_range ? RESP_OKAY : RESP_SLVERR;
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
                w_state_d = W_RESP;
            end
            W_RESP: begin
                if (Bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign awready_d = (w_state_d == W_IDLE) && !aw_held_d;
    assign wready_d  = (w_state_d == W_IDLE) && !w_held_d;

    always_comb begin
        r_state_d = r_state_q;
        ar_addr_d = ar_addr_q;
        r_cnt_d   = r_cnt_q;
        case (r_state_q)
            R_IDLE: begin
                if (ARvalid && arready_q) begin
                    ar_addr_d = ARdata;
                    r_state_d = R_FETCH;
                end
            end
            R_FETCH: begin
                if (w_state_q != W_COMMIT) begin
                    if (READ_LATENCY == 1) begin
                        r_state_d = R_RESP;
                    end else begin
                        r_cnt_d   = LAT_M1;
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_cnt_q == 2'd1) begin
                    r_state_d = R_RESP;
                end else begin
                    r_cnt_d = r_cnt_q - 2'd1;
                end
            end
            R_RESP: begin
                if (Rready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign arready_d = (r_state_d == R_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            r_state_q <= R_IDLE;
            ar_addr_q <= '0;
            r_cnt_q   <= '0;
            arready_q <= 1'b1;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            aw_addr_q <= aw_addr_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bresp_q   <= bresp_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            r_state_q <= r_state_d;
            ar_addr_q <= ar_addr_d;
            r_cnt_q   <= r_cnt_d;
            arready_q <= arready_d;
        end
    end

    // Reads never touch the array during a commit, so the two ports cannot clash.
    assign ram_wr   = (w_state_q == W_COMMIT) && w_in_range && (w_strb_q != '0);
    assign ram_rd   = (r_state_q == R_FETCH) && (w_state_q != W_COMMIT) && r_in_range;
    assign ram_en   = ram_wr || ram_rd;
    assign ram_we   = ram_wr ? w_strb_q : '0;
    assign ram_addr = ram_wr ? w_idx : r_idx;

    mriscv_ram_array #(
        .WORDS (MEM_WORDS),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (w_data_q),
        .rdata (ram_rdata)
    );

    assign AWready = awready_q;
    assign Wready  = wready_q;
    assign ARready = arready_q;
    assign Bvalid  = (w_state_q == W_RESP);
    assign Bresp   = bresp_q;
    assign Rvalid  = (r_state_q == R_RESP);
    assign Rresp   = (Rvalid && !r_in_range) ? RESP_SLVERR : RESP_OKAY;
    assign Rdata   = (Rvalid && r_in_range) ? ram_rdata : '0;

endmodule

// File: tb/tb_mriscv_axi_ram.sv
// Self-checking bench for mriscv_axi_ram: vector table of write/read pairs plus
// hand-written out-of-order, collision and mid-transaction reset sequences.
module tb_mriscv_axi_ram;

    localparam int          MW  = 64;
    localparam logic [31:0] B   = 32'h0000_1000;
    localparam logic [1:0]  OK  = 2'b00;
    localparam logic [1:0]  ERR = 2'b10;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [31:0] AWdata = '0, Wdata = '0, ARdata = '0;
    logic        AWvalid = 1'b0, Wvalid = 1'b0, ARvalid = 1'b0;
    logic        Bready = 1'b0, Rready = 1'b0;
    logic [3:0]  Wstrb = '0;
    logic [2:0]  AWprot = '0, ARprot = '0;
    logic        AWready, Wready, ARready, Bvalid, Rvalid;
    logic [1:0]  Bresp, Rresp;
    logic [31:0] Rdata;

    always #5 clk = ~clk;

    mriscv_axi_ram #(
        .MEM_WORDS    (MW),
        .BASE_ADDR    (B),
        .READ_LATENCY (1)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .AWdata  (AWdata),
        .AWvalid (AWvalid),
        .AWready (AWready),
        .AWprot  (AWprot),
        .Wdata   (Wdata),
        .Wstrb   (Wstrb),
        .Wvalid  (Wvalid),
        .Wready  (Wready),
        .Bvalid  (Bvalid),
        .Bready  (Bready),
        .Bresp   (Bresp),
        .ARdata  (ARdata),
        .ARvalid (ARvalid),
        .ARready (ARready),
        .ARprot  (ARprot),
        .Rdata   (Rdata),
        .Rvalid  (Rvalid),
        .Rready  (Rready),
        .Rresp   (Rresp)
    );

    typedef struct {
        logic        wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  bresp;
        logic [31:0] raddr;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    vec_t       vecs [12];
    logic [1:0] exp_b [$];
    rexp_t      exp_r [$];
    int         n_pass = 0;
    int         n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", nm, act, req);
    endtask

    task automatic issue_write(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, input logic [1:0] resp);
        AWdata = a; Wdata = d; Wstrb = s;
        AWvalid = 1'b1; Wvalid = 1'b1;
        exp_b.push_back(resp);
        @(posedge clk); #1;
        AWvalid = 1'b0; Wvalid = 1'b0;
    endtask

    task automatic issue_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
        rexp_t e;
        e.data = d; e.resp = resp;
        ARdata = a; ARvalid = 1'b1;
        exp_r.push_back(e);
        @(posedge clk); #1;
        ARvalid = 1'b0;
    endtask

    task automatic finish_b(input string tag, input int exp_lat, input int hold);
        int         lat;
        logic [1:0] r0;
        bit         stable;
        lat = 0; stable = 1'b1;
        while (!Bvalid && lat < 64) begin @(posedge clk); #1; lat++; end
        chk({tag, " b_latency"}, 32'(lat), 32'(exp_lat));
        if (Bvalid) begin
            r0 = Bresp;
            repeat (hold) begin
                @(posedge clk); #1;
                if (!Bvalid || Bresp !== r0 || AWready || Wready) stable = 1'b0;
            end
            if (hold > 0) chk({tag, " b_hold"}, 32'(stable), 32'd1);
            if (exp_b.size() > 0) chk({tag, " bresp"}, 32'(Bresp), 32'(exp_b.pop_front()));
            else chk({tag, " b_underflow"}, 32'(exp_b.size()), 32'd1);
            Bready = 1'b1; @(posedge clk); #1; Bready = 1'b0;
            chk({tag, " b_drop"}, 32'(Bvalid), 32'd0);
            chk({tag, " b_ready_back"}, 32'({AWready, Wready}), 32'd3);
        end
    endtask

    task automatic finish_r(input string tag, input int exp_lat, input int hold);
        int          lat;
        logic [31:0] d0;
        logic [1:0]  r0;
        bit          stable;
        rexp_t       e;
        lat = 0; stable = 1'b1;
        while (!Rvalid && lat < 64) begin @(posedge clk); #1; lat++; end
        chk({tag, " r_latency"}, 32'(lat), 32'(exp_lat));
        if (Rvalid) begin
            d0 = Rdata; r0 = Rresp;
            repeat (hold) begin
                @(posedge clk); #1;
                if (!Rvalid || Rdata !== d0 || Rresp !== r0 || ARready) stable = 1'b0;
            end
            if (hold > 0) chk({tag, " r_hold"}, 32'(stable), 32'd1);
            if (exp_r.size() > 0) begin
                e = exp_r.pop_front();
                chk({tag, " rdata"}, Rdata, e.data);
                chk({tag, " rresp"}, 32'(Rresp), 32'(e.resp));
            end else begin
                chk({tag, " r_underflow"}, 32'(exp_r.size()), 32'd1);
            end
            Rready = 1'b1; @(posedge clk); #1; Rready = 1'b0;
            chk({tag, " r_drop"}, 32'(Rvalid), 32'd0);
            chk({tag, " ar_ready_back"}, 32'(ARready), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0]  = '{1'b1, B + 32'h10,  32'hDEADBEEF, 4'hF, OK,  B + 32'h10,  32'hDEADBEEF, OK};
        vecs[1]  = '{1'b1, B + 32'h20,  32'h11223344, 4'hF, OK,  B + 32'h20,  32'h11223344, OK};
        vecs[2]  = '{1'b1, B + 32'h20,  32'hAABBCCDD, 4'h5, OK,  B + 32'h20,  32'h11BB33DD, OK};
        vecs[3]  = '{1'b1, B + 32'h24,  32'h12345678, 4'hF, OK,  B + 32'h24,  32'h12345678, OK};
        vecs[4]  = '{1'b1, B + 32'h24,  32'hFFFFFFFF, 4'h0, OK,  B + 32'h24,  32'h12345678, OK};
        vecs[5]  = '{1'b1, B + 32'h00,  32'h01020304, 4'hF, OK,  B + 32'h00,  32'h01020304, OK};
        vecs[6]  = '{1'b1, B + 32'h100, 32'h55555555, 4'hF, ERR, B + 32'h100, 32'h00000000, ERR};
        vecs[7]  = '{1'b0, 32'h0,       32'h0,        4'h0, OK,  B + 32'h00,  32'h01020304, OK};
        vecs[8]  = '{1'b1, B + 32'hFF,  32'hA5A5A5A5, 4'hF, OK,  B + 32'hFC,  32'hA5A5A5A5, OK};
        vecs[9]  = '{1'b1, B - 32'h4,   32'h66666666, 4'hF, ERR, B - 32'h4,   32'h00000000, ERR};
        vecs[10] = '{1'b0, 32'h0,       32'h0,        4'h0, OK,  B + 32'hFC,  32'hA5A5A5A5, OK};
        vecs[11] = '{1'b1, B + 32'h22,  32'h99887766, 4'hA, OK,  B + 32'h20,  32'h99BB77DD, OK};

        #2 rstn = 1'b0;
        #1;
        chk("rst ready", 32'({AWready, Wready, ARready}), 32'd7);
        chk("rst valid", 32'({Bvalid, Rvalid}), 32'd0);
        chk("rst resp", 32'({Bresp, Rresp}), 32'd0);
        chk("rst rdata", Rdata, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) begin
                issue_write(vecs[i].waddr, vecs[i].wdata, vecs[i].strb, vecs[i].bresp);
                finish_b($sformatf("v%0d", i), 1, 0);
            end
            issue_read(vecs[i].raddr, vecs[i].rdata, vecs[i].rresp);
            finish_r($sformatf("v%0d", i), 1, i % 3);
        end

        // W three cycles ahead of AW, then Bready withheld for five cycles.
        Wdata = 32'h600DF00D; Wstrb = 4'hF; Wvalid = 1'b1;
        exp_b.push_back(OK);
        @(posedge clk); #1;
        Wvalid = 1'b0;
        chk("ooo wready_low", 32'(Wready), 32'd0);
        chk("ooo awready_high", 32'(AWready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("ooo no_bvalid", 32'(Bvalid), 32'd0);
        AWdata = B + 32'h30; AWvalid = 1'b1;
        @(posedge clk); #1;
        AWvalid = 1'b0;
        finish_b("ooo", 1, 5);
        issue_read(B + 32'h30, 32'h600DF00D, OK);
        finish_r("ooo", 1, 0);

        // Commit and fetch of the same word in the same cycle.
        issue_write(B + 32'h40, 32'h11111111, 4'hF, OK);
        finish_b("coll_pre", 1, 0);
        AWdata = B + 32'h40; Wdata = 32'hCAFEF00D; Wstrb = 4'hF; ARdata = B + 32'h40;
        AWvalid = 1'b1; Wvalid = 1'b1; ARvalid = 1'b1;
        exp_b.push_back(OK);
        exp_r.push_back('{32'hCAFEF00D, OK});
        @(posedge clk); #1;
        AWvalid = 1'b0; Wvalid = 1'b0; ARvalid = 1'b0;
        finish_r("coll", 2, 0);
        finish_b("coll", 0, 0);

        // Reset while both responses are pending.
        issue_write(B + 32'h50, 32'h5A5A0001, 4'hF, OK);
        finish_b("rst_pre", 1, 0);
        AWdata = B + 32'h54; Wdata = 32'h77777777; Wstrb = 4'hF; ARdata = B + 32'h50;
        AWvalid = 1'b1; Wvalid = 1'b1; ARvalid = 1'b1;
        @(posedge clk); #1;
        AWvalid = 1'b0; Wvalid = 1'b0; ARvalid = 1'b0;
        n = 0;
        while (!(Bvalid && Rvalid) && n < 64) begin @(posedge clk); #1; n++; end
        chk("rst both_valid", 32'({Bvalid, Rvalid}), 32'd3);
        rstn = 1'b0;
        #1;
        chk("rst_mid valid", 32'({Bvalid, Rvalid}), 32'd0);
        chk("rst_mid ready", 32'({AWready, Wready, ARready}), 32'd7);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        chk("rst_rel ready", 32'({AWready, Wready, ARready}), 32'd7);
        issue_read(B + 32'h50, 32'h5A5A0001, OK);
        finish_r("rst_post50", 1, 0);
        issue_read(B + 32'h54, 32'h77777777, OK);
        finish_r("rst_post54", 1, 0);

        chk("sb drained", 32'(exp_b.size() + exp_r.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
